// File: rtl/md_sched.sv
// md_sched: sequencing controller for the EX-stage multiply/divide resources.
// Accepts one MULT/MULTU/DIV/DIVU request at a time and latches its operands.
// It drives the pipelined multiplier and the iterative divider, and requests
// an EX stall while they work. It issues exactly one HI/LO write per accepted
// instruction, aligned with pipeline advance.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no operation in flight, waiting for a request from EX
// MUL_WAIT | operands on the multiplier, counting down its latency
// DIV_BUSY | divider started, waiting for div_ready
// DONE     | result captured, waiting for EX to advance to write HI/LO
module md_sched #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        ex_allowin,
  input  logic        flush,
  output logic        stallreq,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_t      state_q, state_d;
  logic        sgn_q, sgn_d;   // signed operation (op[0] == 0)
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        stall_raw;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, capture and output decode; flush overrides every other event.
  always_comb begin
    state_d     = state_q;
    sgn_d       = sgn_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    stall_raw   = 1'b0;
    mul_signed  = 1'b0;
    mul_ina     = '0;
    mul_inb     = '0;
    div_start   = 1'b0;
    div_signed  = 1'b0;
    div_opdata1 = '0;
    div_opdata2 = '0;
    div_annul   = 1'b0;
    hilo_we     = 1'b0;
    hi_wdata    = '0;
    lo_wdata    = '0;

    case (state_q)
      IDLE: begin
        // The request takes priority over ex_allowin: stalling blocks the advance.
        stall_raw = req_valid & ~flush;
        if (req_valid && !flush) begin
          sgn_d  = ~req_op[0];
          src1_d = req_src1;
          src2_d = req_src2;
          if (!req_op[1]) begin
            state_d = MUL_WAIT;
            cnt_d   = CNT_INIT;
          end else if (req_src2 != 32'd0) begin
            state_d = DIV_BUSY;
          end else begin
            // Divide by zero resolves without touching the divider.
            state_d = DONE;
            hi_d    = req_src1;
            lo_d    = 32'hFFFF_FFFF;
          end
        end
      end
      MUL_WAIT: begin
        stall_raw  = 1'b1;
        mul_signed = sgn_q;
        mul_ina    = src1_q;
        mul_inb    = src2_q;
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = DONE;
          hi_d    = mul_result[63:32];
          lo_d    = mul_result[31:0];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DIV_BUSY: begin
        stall_raw   = 1'b1;
        div_signed  = sgn_q;
        div_opdata1 = src1_q;
        div_opdata2 = src2_q;
        if (flush) begin
          div_annul = 1'b1;
          state_d   = IDLE;
        end else if (div_ready) begin
          state_d = DONE;
          hi_d    = div_result[63:32];
          lo_d    = div_result[31:0];
        end else begin
          div_start = 1'b1;
        end
      end
      DONE: begin
        // Held here while EX is stalled; a lingering req_valid is ignored.
        hi_wdata = hi_q;
        lo_wdata = lo_q;
        if (flush) begin
          state_d = IDLE;
        end else if (ex_allowin) begin
          hilo_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Keep the stall request quiet while reset is asserted.
  assign stallreq = resetn & stall_raw;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;

  localparam int unsigned MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        ex_allowin, flush;
  logic        stallreq, busy, mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul, div_ready;
  logic [31:0] div_opdata1, div_opdata2;
  logic [63:0] div_result;
  logic        hilo_we;
  logic [31:0] hi_wdata, lo_wdata;

  int n_chk  = 0;
  int n_pass = 0;
  int n_we   = 0;
  int n_acc  = 0;
  logic [63:0] sb[$];

  md_sched #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
    .ex_allowin(ex_allowin), .flush(flush),
    .stallreq(stallreq), .busy(busy),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed),
    .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
    .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] mul_ref(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = sg ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sg ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] div_ref(input logic sg, input logic [31:0] a, input logic [31:0] b);
    if (sg) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    return {a % b, a / b};
  endfunction

  // Multiplier model: result visible MUL_LAT-1 edges after operands (MUL_LAT=2).
  logic [63:0] mul_pipe;
  always_ff @(posedge clk) mul_pipe <= mul_ref(mul_signed, mul_ina, mul_inb);
  assign mul_result = mul_pipe;

  // Divider model: div_ready in the 33rd cycle of a continuous div_start.
  int dcnt;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dcnt <= 0; div_ready <= 1'b0; div_result <= '0;
    end else if (!div_start || div_annul) begin
      dcnt <= 0; div_ready <= 1'b0;
    end else if (dcnt == 31) begin
      div_ready  <= 1'b1;
      div_result <= div_ref(div_signed, div_opdata1, div_opdata2);
      dcnt <= 0;
    end else begin
      dcnt <= dcnt + 1;
    end
  end

  // Scoreboard monitor: every write strobe consumes one expected result.
  always @(negedge clk) begin
    if (resetn && hilo_we) begin
      n_we++;
      if (sb.size() == 0) chk("we_spurious", 1, 0);
      else chk("hilo_data", {hi_wdata, lo_wdata}, sb.pop_front());
    end
  end

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [63:0] exp,
                        input int exp_stall, input int exp_dstart);
    int stall = 0;
    int dst = 0;
    logic seen = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2; ex_allowin = 1'b1;
    sb.push_back(exp); n_acc++;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (c == 0) chk({tag, "_stall_first"}, stallreq, 1);
      if (c == 1 && !op[1]) chk({tag, "_mul_ops"}, {mul_signed, mul_ina, mul_inb}, {~op[0], s1, s2});
      if (c == 1 && op[1] && s2 != 0) chk({tag, "_div_ops"}, {div_signed, div_opdata1, div_opdata2}, {~op[0], s1, s2});
      if (stallreq) stall++;
      if (div_start) dst++;
      if (hilo_we) seen = 1'b1;
    end
    chk({tag, "_we_seen"}, seen, 1);
    chk({tag, "_stall_cycles"}, stall, exp_stall);
    chk({tag, "_div_start_cycles"}, dst, exp_dstart);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_after"}, {busy, hilo_we}, 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ctl"}, {stallreq, busy, div_start, div_annul, hilo_we, mul_signed, div_signed}, 0);
    chk({tag, "_data"}, {mul_ina | mul_inb | div_opdata1 | div_opdata2 | hi_wdata | lo_wdata}, 0);
  endtask

  initial begin
    logic done_seen;
    resetn = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_src1 = '0; req_src2 = '0;
    ex_allowin = 1'b0; flush = 1'b0;
    #3;
    chk_zero_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;

    run_op("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, MUL_LAT + 1, 0);
    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT + 1, 0);
    run_op("divu", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 32);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, 32);
    run_op("divu_zero", 2'b11, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1, 0);
    run_op("div_zero", 2'b10, 32'h8000_0000, 32'd0, {32'h8000_0000, 32'hFFFF_FFFF}, 1, 0);

    // DONE held with EX stalled and req_valid still present.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b11; req_src1 = 32'd100; req_src2 = 32'd7; ex_allowin = 1'b0;
    sb.push_back({32'd2, 32'd14}); n_acc++;
    done_seen = 1'b0;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      @(negedge clk);
      if (busy && !stallreq) done_seen = 1'b1;
    end
    chk("hold_reach_done", done_seen, 1);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      chk("hold_no_we", {hilo_we, div_start, stallreq}, 0);
      chk("hold_data", {hi_wdata, lo_wdata}, {32'd2, 32'd14});
    end
    @(posedge clk); #1;
    ex_allowin = 1'b1;
    @(negedge clk);
    chk("hold_release_we", hilo_we, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("hold_single_we", {hilo_we, busy}, 0);

    // Flush in the 10th cycle of DIV_BUSY.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b11; req_src1 = 32'd100; req_src2 = 32'd7;
    for (int c = 0; c < 10; c++) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_annul", {div_annul, div_start, hilo_we}, 3'b100);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle", {busy, div_annul, div_start, hilo_we}, 0);

    // Reset asserted in the middle of MUL_WAIT.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'd9; req_src2 = 32'd9;
    @(posedge clk); #3;
    chk("rst_mid_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk_zero_outputs("rst_mid");
    @(posedge clk); #1;
    req_valid = 1'b0; resetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_after", {busy, hilo_we}, 0);
    end

    chk("we_count", n_we, n_acc);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencing controller for the EX-stage multiply and divide resources.
- Accepts one MULT/MULTU/DIV/DIVU request at a time from EX and latches its operands.
- Drives the pipelined multiplier and the iterative divider, and raises the EX stall request while they work.
- Issues exactly one HI/LO write per instruction, aligned with pipeline advance; supports flush/annul.

Parameters:
- MUL_LAT, 2: multiplier result latency in cycles after operands are presented; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- req_valid  input  1  EX holds a mul/div instruction this cycle.
- req_op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- req_src1  input  32  rs operand (dividend / multiplicand).
- req_src2  input  32  rt operand (divisor / multiplier).
- ex_allowin  input  1  EX result advances to MEM this cycle (stall[3]==NoStop).
- flush  input  1  kill the in-flight operation.
- stallreq  output  1  stall request to the stall controller.
- busy  output  1  state != IDLE.
- mul_signed  output  1  to multiplier.
- mul_ina, mul_inb  output  32 each  multiplier operands.
- mul_result  input  64  {hi,lo} from multiplier.
- div_start  output  1  divider start.
- div_signed  output  1  divider signedness.
- div_opdata1, div_opdata2  output  32 each  divider operands.
- div_annul  output  1  divider abort.
- div_ready  input  1  divider result valid.
- div_result  input  64  {remainder,quotient} from divider.
- hilo_we  output  1  HI/LO write strobe.
- hi_wdata, lo_wdata  output  32 each  HI/LO write data.

Behaviour:
- States: IDLE, MUL_WAIT, DIV_BUSY, DONE.
- Reset (resetn=0, async): state=IDLE; cnt=0; operand and result registers=0. All outputs 0: stallreq, busy, div_start, div_annul, hilo_we, mul_signed, div_signed, operands, write data.
- IDLE, req_valid=1, flush=0: latch op, src1, src2.
  - op[1]=0: go to MUL_WAIT with cnt=MUL_LAT-1.
  - op[1]=1 and src2!=0: go to DIV_BUSY.
  - op[1]=1 and src2==0: go directly to DONE with hi=src1, lo=32'hFFFFFFFF; divider never started.
- stallreq = (IDLE & req_valid & ~flush) | MUL_WAIT | DIV_BUSY. Combinational. Deasserted in DONE so EX can advance.
- MUL_WAIT:
  - mul_ina/mul_inb = latched operands; mul_signed = ~op[0]; all three are zero in other states.
  - cnt decrements each cycle.
  - At cnt==0: capture mul_result into hi/lo registers and go to DONE.
  - Total stall for a multiply = MUL_LAT+1 cycles.
- DIV_BUSY:
  - div_start=1, div_opdata1/2 = latched operands, div_signed = ~op[0].
  - div_start is held until the cycle div_ready=1. In that cycle capture hi=div_result[63:32], lo=div_result[31:0]; div_start=0; go to DONE.
- DONE:
  - hi_wdata/lo_wdata = captured values.
  - hilo_we=1 combinationally only when ex_allowin=1. On that edge go to IDLE.
  - If ex_allowin=0, hold DONE with data stable. The still-present req_valid must not restart the operation.
  - Exactly one hilo_we cycle per accepted request.
- flush=1 in any state:
  - Next state IDLE; hilo_we=0 that cycle.
  - If current state is DIV_BUSY: div_annul=1 for that cycle and div_start=0.
  - flush has priority over ex_allowin, div_ready and cnt==0.
- IDLE with req_valid=1 and ex_allowin=1 in the same cycle: the request wins, and stallreq blocks the advance.
- op decode uses req_op only; the controller never inspects instruction bits.

Test Plan:
- MULT, src1=32'hFFFFFFFE, src2=3, MUL_LAT=2: stallreq high 3 cycles, then hilo_we=1 for 1 cycle with hi=32'hFFFFFFFF, lo=32'hFFFFFFFA; busy low next cycle.
- DIVU, 100/7, divider model ready after 33 cycles: div_start high until ready; hilo_we pulse with hi=2, lo=14; exactly one pulse.
- DIV, src1=32'hFFFFFFF9 (-7), src2=2: hi=32'hFFFFFFFF, lo=32'hFFFFFFFD.
- DIVU by zero, src1=5: no div_start; DONE next cycle; hi=5, lo=32'hFFFFFFFF.
- DONE with ex_allowin=0 for 4 cycles, req_valid held: hilo_we stays 0, data stable, no new div_start; ex_allowin=1 gives a single hilo_we.
- flush at cycle 10 of DIV_BUSY: div_annul pulse 1 cycle, state IDLE, no hilo_we.
- resetn dropped mid-MUL_WAIT: all outputs 0 immediately, no hilo_we after release.
